keypad_scan: RTL and testbench
==============================

# keypad_scan

4x4 matrix-keypad scanner and debouncer: the input-side counterpart to the board's multiplexed 7-segment display driver. It drives one keypad row low at a time, samples the active-low columns, debounces whole-matrix frames, and reports each debounced key press once as a 4-bit code with a one-cycle strobe. The block sits between the board keypad pins and downstream control logic, such as a digit-entry FSM that feeds the display.

## Interface
- SCAN_CYC, 200_000: clk cycles each row is driven (2 ms at 100 MHz); must be >= 4.
- DEB_CNT, 4: consecutive agreeing frames required for press or release; must be >= 2.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- key_col  in  4  keypad columns, active-low (a pressed key pulls its column low); asynchronous to clk.
- key_row  out  4  keypad row drive, active-low, exactly one bit low at any time.
- key_valid  out  1  one-cycle strobe: a new debounced press is reported.
- key_code  out  4  {row_idx[1:0], col_idx[1:0]} of the last reported key; held between strobes.
- key_down  out  1  high while a debounced key is held.

## Operation
- key_col passes through a 2-flop synchronizer before any use.
- Row scan:
  - A dwell counter runs 0..SCAN_CYC-1, and row_idx advances 0..3 on each wrap.
  - key_row = ~(4'b0001 << row_idx).
  - Columns are sampled on the last dwell cycle of each row, giving settling time.
- Frame:
  - A frame is 4 row dwells (4*SCAN_CYC cycles). Frame end is the last dwell cycle of row 3.
  - frame_hit = any pressed sample in the frame.
  - frame_code = lowest {row,col} among pressed samples; multiple keys resolve to the lowest code.
  - Per-row samples are accumulated and cleared at frame end.
- Debounce FSM (IDLE, CAND, HELD, REL) is evaluated only at frame end. cnt is 0..DEB_CNT, saturating.
  - IDLE:
    - hit -> CAND, cand=frame_code, cnt=1.
    - no hit -> stay.
  - CAND:
    - hit and code==cand -> cnt+1. When cnt+1==DEB_CNT -> HELD, key_code<=cand, key_valid pulse.
    - hit and code!=cand -> stay, cand=frame_code, cnt=1.
    - no hit -> IDLE.
  - HELD:
    - hit (any code) -> stay. No repeat, and no report of a second or changed key.
    - no hit -> REL, cnt=1.
  - REL:
    - no hit -> cnt+1. When cnt+1==DEB_CNT -> IDLE.
    - hit -> HELD. No new key_valid.
- key_down = 1 in HELD and REL; 0 in IDLE and CAND.

## Timing
- Reset (rst=0 at a clk edge):
  - dwell counter 0, row_idx 0, key_row 4'b1110, FSM IDLE, cnt 0.
  - Accumulated samples and synchronizer cleared (synchronizer to 4'b1111).
  - key_valid 0, key_code 4'h0, key_down 0.
- Reset mid-operation (any state) discards candidate and held state. A press already held then needs DEB_CNT full frames after reset release before it is reported.
- Pin-to-sample latency: 2 synchronizer cycles. Since SCAN_CYC >= 4, the sample always reflects the current row.
- key_valid is registered: it is high for exactly the single cycle after the frame-end edge on which cnt reaches DEB_CNT.
- key_code updates on that same edge and is stable thereafter.
- key_down rises with key_valid. It falls on the cycle after the frame end that completes DEB_CNT release frames.
- Minimum press-to-report time: DEB_CNT frames.
- Minimum spacing between two key_valid strobes: 2*DEB_CNT frames (a full release, then a new press).
- Counters wrap only at their defined terminal counts; no other wrap-around is permitted.

## Structure
- Package keypad_pkg:
  - ROWS=4 and COLS=4 constants.
  - state enum (IDLE, CAND, HELD, REL).
  - key-code width constant (4).
- Sub-module keypad_row_scan (parameter SCAN_CYC):
  - Owns the dwell counter and row_idx.
  - Outputs key_row, sample_stb (last dwell cycle), frame_end (sample_stb with row 3), and row_idx.
- The top level contains the synchronizer, frame accumulation/priority encode, and debounce FSM.

## Test plan
All scenarios use SCAN_CYC=4, DEB_CNT=3 (frame = 16 cycles).
- Row scan: release reset, idle columns 4'b1111 -> key_row cycles 1110,1101,1011,0111, 4 cycles each. No key_valid, key_down=0.
- Clean press: hold key row1/col2 for 6 frames, then release -> exactly one key_valid, with key_code 4'h6, one cycle after the 3rd frame end.
  - key_down is 1 from then until one cycle after the 3rd consecutive empty frame end.
- Bounce: press row2/col0 for 2 frames, release 1 frame, press 2 frames, release -> no key_valid, key_down stays 0.
- Multi-key: row0/col3 and row2/col1 pressed together for 4 frames -> single key_valid with key_code 4'h3.
- Hold and change: after key 4'h6 is reported, switch to key 4'h9 without release -> no key_valid, key_code stays 4'h6.
  - After a full release (3 empty frames) and a new 3-frame press of key 4'h9 -> key_valid with 4'h9.
- Reset mid-HELD: assert rst=0 for 1 cycle while key 4'h5 is held -> next cycle key_down=0, key_row=1110.
  - With the key still held, key_valid (code 4'h5) follows 3 full frames after reset release.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and column priority helper for the keypad scanner.
package keypad_pkg;

    localparam int ROWS   = 4;
    localparam int COLS   = 4;
    localparam int CODE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        CAND,
        HELD,
        REL
    } state_e;

    // Index of the lowest pressed column; only meaningful when pressed != 0.
    function automatic logic [1:0] lowest_col(input logic [COLS-1:0] pressed);
        logic [1:0] idx;
        idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (pressed[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Debounced key report bus from the scanner to downstream control logic.
interface keypad_scan_if;
    import keypad_pkg::*;

    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_down;

    modport master (output key_valid, key_code, key_down);
    modport slave  (input  key_valid, key_code, key_down);
endinterface

// File: rtl/keypad_row_scan.sv
// Row dwell timer: drives one row low at a time and flags the sampling and frame-end cycles.
module keypad_row_scan #(
    parameter int SCAN_CYC = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] key_row,
    output logic       sample_stb,
    output logic       frame_end,
    output logic [1:0] row_idx
);

    localparam int DW = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYC - 1);

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;

    always_comb begin
        sample_stb = (dwell_q == DWELL_LAST);
        frame_end  = sample_stb && (row_q == 2'd3);
        dwell_d    = sample_stb ? '0 : dwell_q + DW'(1);
        row_d      = sample_stb ? row_q + 2'd1 : row_q;
        key_row    = ~(4'b0001 << row_q);
        row_idx    = row_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dwell_q <= '0;
            row_q   <= '0;
        end else begin
            dwell_q <= dwell_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column synchronizer, per-frame priority encode and debounce FSM.
//   state | meaning
//   IDLE  | no key, waiting for a pressed frame
//   CAND  | candidate key seen, counting agreeing frames
//   HELD  | key reported and still pressed
//   REL   | key held, counting empty frames before release
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_CYC = 200_000,
    parameter int DEB_CNT  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COLS-1:0]  key_col,
    output logic [ROWS-1:0]  key_row,
    keypad_scan_if.master    kp
);

    localparam int CW = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEB_CNT);

    logic              sample_stb, frame_end;
    logic [1:0]        row_idx;

    logic [COLS-1:0]   col_s1_q, col_s2_q;
    logic              acc_hit_q, acc_hit_d;
    logic [CODE_W-1:0] acc_code_q, acc_code_d;
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;

    logic [COLS-1:0]   pressed;
    logic              row_hit, frame_hit;
    logic [CODE_W-1:0] row_code, frame_code;

    keypad_row_scan #(.SCAN_CYC(SCAN_CYC)) u_row_scan (
        .clk        (clk),
        .rst        (rst),
        .key_row    (key_row),
        .sample_stb (sample_stb),
        .frame_end  (frame_end),
        .row_idx    (row_idx)
    );

    // Rows are scanned in ascending order, so the first row with a hit owns the lowest code.
    always_comb begin
        pressed    = ~col_s2_q;
        row_hit    = |pressed;
        row_code   = {row_idx, lowest_col(pressed)};
        frame_hit  = acc_hit_q | row_hit;
        frame_code = acc_hit_q ? acc_code_q : row_code;

        acc_hit_d  = acc_hit_q;
        acc_code_d = acc_code_q;
        if (frame_end) begin
            acc_hit_d  = 1'b0;
            acc_code_d = '0;
        end else if (sample_stb && row_hit && !acc_hit_q) begin
            acc_hit_d  = 1'b1;
            acc_code_d = row_code;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        cnt_inc = cnt_q + CW'(1);

        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_hit) begin
                        state_d = CAND;
                        cand_d  = frame_code;
                        cnt_d   = CW'(1);
                    end
                end
                CAND: begin
                    if (!frame_hit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (frame_code != cand_q) begin
                        cand_d = frame_code;
                        cnt_d  = CW'(1);
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d = HELD;
                            code_d  = cand_q;
                            valid_d = 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!frame_hit) begin
                        state_d = REL;
                        cnt_d   = CW'(1);
                    end
                end
                REL: begin
                    if (frame_hit) begin
                        state_d = HELD;
                        cnt_d   = CNT_DONE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_s1_q   <= '1;
            col_s2_q   <= '1;
            acc_hit_q  <= 1'b0;
            acc_code_q <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            col_s1_q   <= key_col;
            col_s2_q   <= col_s1_q;
            acc_hit_q  <= acc_hit_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
        end
    end

    assign kp.key_valid = valid_q;
    assign kp.key_code  = code_q;
    assign kp.key_down  = (state_q == HELD) || (state_q == REL);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix (SCAN_CYC=4, DEB_CNT=3).
module tb_keypad_scan;
    import keypad_pkg::*;

    localparam int SCAN  = 4;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * SCAN;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic [15:0] keys = '0;
    logic [3:0]  exp_row;

    int vectors    = 0;
    int miscompares = 0;
    int vcount     = 0;

    keypad_scan_if kp ();

    keypad_scan #(.SCAN_CYC(SCAN), .DEB_CNT(DEB)) dut (
        .clk     (clk),
        .rst     (rst),
        .key_col (key_col),
        .key_row (key_row),
        .kp      (kp)
    );

    always #5 clk = ~clk;

    // Pressed key {r,c} shorts row r to column c; columns idle high.
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!key_row[r] && keys[r*4+c]) key_col[c] = 1'b0;
    end

    always @(posedge clk) if (kp.key_valid === 1'b1) vcount++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frames(input int n);
        cycles(n * FRAME);
    endtask

    initial begin
        // reset
        cycles(3);
        check("rst_row", key_row, 4'hE);
        check("rst_valid", kp.key_valid, 1'b0);
        check("rst_code", kp.key_code, 4'h0);
        check("rst_down", kp.key_down, 1'b0);
        rst = 1'b1;

        // row scan, idle columns
        for (int i = 0; i < FRAME; i++) begin
            exp_row = ~(4'b0001 << (i / SCAN));
            check("row_scan", key_row, exp_row);
            cycles(1);
        end
        check("row_scan_wrap", key_row, 4'hE);
        check("idle_down", kp.key_down, 1'b0);
        check("idle_vcount", vcount, 0);

        // clean press of row1/col2
        keys = 16'h1 << 6;
        frames(2);
        check("clean_early_valid", kp.key_valid, 1'b0);
        check("clean_early_down", kp.key_down, 1'b0);
        frames(1);
        check("clean_valid", kp.key_valid, 1'b1);
        check("clean_code", kp.key_code, 4'h6);
        check("clean_down", kp.key_down, 1'b1);
        cycles(1);
        check("clean_valid_1cyc", kp.key_valid, 1'b0);
        cycles(FRAME - 1);
        frames(2);
        keys = '0;
        frames(2);
        check("clean_rel_down", kp.key_down, 1'b1);
        frames(1);
        check("clean_released", kp.key_down, 1'b0);
        check("clean_vcount", vcount, 1);

        // bounce on row2/col0
        keys = 16'h1 << 8;
        frames(2);
        check("bounce_a_down", kp.key_down, 1'b0);
        keys = '0;
        frames(1);
        keys = 16'h1 << 8;
        frames(2);
        check("bounce_b_down", kp.key_down, 1'b0);
        keys = '0;
        frames(1);
        check("bounce_vcount", vcount, 1);
        check("bounce_code", kp.key_code, 4'h6);

        // two keys together resolve to the lowest code
        keys = (16'h1 << 3) | (16'h1 << 9);
        frames(3);
        check("multi_valid", kp.key_valid, 1'b1);
        check("multi_code", kp.key_code, 4'h3);
        frames(1);
        keys = '0;
        frames(3);
        check("multi_released", kp.key_down, 1'b0);
        check("multi_vcount", vcount, 2);

        // hold and change key without release
        keys = 16'h1 << 6;
        frames(3);
        check("hold_valid", kp.key_valid, 1'b1);
        check("hold_code", kp.key_code, 4'h6);
        keys = 16'h1 << 9;
        frames(3);
        check("change_code", kp.key_code, 4'h6);
        check("change_down", kp.key_down, 1'b1);
        check("change_vcount", vcount, 3);
        keys = '0;
        frames(3);
        check("change_released", kp.key_down, 1'b0);
        keys = 16'h1 << 9;
        frames(2);
        check("new_early_down", kp.key_down, 1'b0);
        frames(1);
        check("new_valid", kp.key_valid, 1'b1);
        check("new_code", kp.key_code, 4'h9);
        keys = '0;
        frames(3);
        check("new_vcount", vcount, 4);

        // reset while a key is held
        keys = 16'h1 << 5;
        frames(3);
        check("pre_rst_valid", kp.key_valid, 1'b1);
        check("pre_rst_code", kp.key_code, 4'h5);
        frames(1);
        check("pre_rst_down", kp.key_down, 1'b1);
        rst = 1'b0;
        cycles(1);
        rst = 1'b1;
        check("mid_rst_down", kp.key_down, 1'b0);
        check("mid_rst_row", key_row, 4'hE);
        check("mid_rst_code", kp.key_code, 4'h0);
        frames(2);
        check("post_rst_early_down", kp.key_down, 1'b0);
        check("post_rst_vcount", vcount, 5);
        frames(1);
        check("post_rst_valid", kp.key_valid, 1'b1);
        check("post_rst_code", kp.key_code, 4'h5);
        check("post_rst_down", kp.key_down, 1'b1);
        keys = '0;
        frames(3);
        check("final_vcount", vcount, 6);
        check("final_down", kp.key_down, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
